// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared types and constants for the APB memory slave.
//   apb_mem_state_t : transfer FSM states (IDLE, WAIT, DONE)
//   WAIT_NONE/WAIT_FIXED/WAIT_RAND : WAIT_MODE parameter encodings
//   LFSR_SEED       : reset value of the wait-state LFSR
//   lfsr_next()     : one step of the 8-bit wait-state LFSR
package apb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_mem_state_t;

    localparam int unsigned WAIT_NONE  = 0;
    localparam int unsigned WAIT_FIXED = 1;
    localparam int unsigned WAIT_RAND  = 2;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

endpackage

// File: rtl/apb_wait_gen.sv
// apb_wait_gen: wait-state count source for apb_mem_slave.
// Holds a free-running 8-bit LFSR and selects the per-transfer wait count.
// Ports:
//   clk    in  1  clock, rising edge
//   reset  in  1  asynchronous active-low reset
//   wait_o out 4  wait states for a transfer whose SETUP edge is the next edge
module apb_wait_gen
    import apb_mem_pkg::*;
#(
    parameter int unsigned WAIT_MODE  = WAIT_RAND,
    parameter int unsigned FIXED_WAIT = 2,
    parameter int unsigned WAIT_MASK  = 7
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] wait_o
);

    logic [7:0] r_lfsr;
    logic [3:0] w_wait;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    always_comb begin
        w_wait = '0;
        case (WAIT_MODE)
            WAIT_FIXED: w_wait = 4'(FIXED_WAIT);
            WAIT_RAND:  w_wait = r_lfsr[3:0] & 4'(WAIT_MASK);
            default:    w_wait = '0;
        endcase
    end

    assign wait_o = w_wait;

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: parametrised APB slave backed by an on-chip word memory.
// Byte-strobe writes, programmable wait states (via apb_wait_gen) and,
// when the macro APB_MEM_SLVERR_EN is defined, slave-error reporting for
// word indices >= DEPTH. Without the macro pslverr_o is tied 0 and the
// index is truncated to clog2(DEPTH) bits.
// Ports:
//   clk        in  1         clock, rising edge
//   reset      in  1         asynchronous active-low reset
//   psel_i     in  1         APB select
//   penable_i  in  1         APB enable
//   pwrite_i   in  1         1 = write, 0 = read
//   paddr_i    in  ADDR_W    byte address
//   pwdata_i   in  DATA_W    write data
//   pstrb_i    in  DATA_W/8  write byte strobes
//   prdata_o   out DATA_W    registered read data
//   pready_o   out 1         transfer complete (state == DONE)
//   pslverr_o  out 1         error response, valid with pready_o
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned WAIT_MODE  = WAIT_RAND,
    parameter int unsigned FIXED_WAIT = 2,
    parameter int unsigned WAIT_MASK  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_W-1:0]     paddr_i,
    input  logic [DATA_W-1:0]     pwdata_i,
    input  logic [DATA_W/8-1:0]   pstrb_i,
    output logic [DATA_W-1:0]     prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned BSH    = $clog2(NB);
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef APB_MEM_SLVERR_EN
    // Keep the full index so out-of-range accesses can be detected.
    localparam int unsigned LIDX_W = ADDR_W - BSH;
`else
    localparam int unsigned LIDX_W = MEM_AW;
`endif

    logic [DATA_W-1:0]  r_mem [DEPTH];

    apb_mem_state_t     r_state;
    apb_mem_state_t     w_next;
    logic [LIDX_W-1:0]  r_idx;
    logic               r_write;
    logic [DATA_W-1:0]  r_wdata;
    logic [NB-1:0]      r_strb;
    logic [3:0]         r_cnt;
    logic [DATA_W-1:0]  r_prdata;

    logic [3:0]         w_wait;
    logic               w_setup;
    logic               w_enter_done;
    logic [LIDX_W-1:0]  w_cur_idx;
    logic               w_cur_write;
    logic               w_cur_ok;
    logic               w_ok;
    logic               w_commit;
    logic               w_unused_paddr;

    // Low address bits (and, without error reporting, high bits) are ignored.
    assign w_unused_paddr = ^paddr_i;

    function automatic logic idx_ok(input logic [LIDX_W-1:0] idx);
        return ({1'b0, idx} < (LIDX_W+1)'(DEPTH));
    endfunction

    apb_wait_gen #(
        .WAIT_MODE  (WAIT_MODE),
        .FIXED_WAIT (FIXED_WAIT),
        .WAIT_MASK  (WAIT_MASK)
    ) u_wait_gen (
        .clk    (clk),
        .reset  (reset),
        .wait_o (w_wait)
    );

    assign w_setup = (r_state == IDLE) && psel_i && !penable_i;

    // When DONE is entered straight from IDLE the transfer attributes are
    // still on the bus, not yet in the latches.
    assign w_cur_idx   = (r_state == IDLE) ? paddr_i[BSH +: LIDX_W] : r_idx;
    assign w_cur_write = (r_state == IDLE) ? pwrite_i : r_write;
    assign w_cur_ok    = idx_ok(w_cur_idx);
    assign w_ok        = idx_ok(r_idx);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_setup) w_next = (w_wait == 4'd0) ? DONE : WAIT;
            WAIT: begin
                if (!psel_i)            w_next = IDLE;
                else if (r_cnt == 4'd1) w_next = DONE;
            end
            DONE: if (!psel_i || penable_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_enter_done = (r_state != DONE) && (w_next == DONE);
    assign w_commit     = (r_state == DONE) && psel_i && penable_i && r_write && w_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_strb   <= '0;
            r_cnt    <= '0;
            r_prdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_setup) begin
                r_idx   <= paddr_i[BSH +: LIDX_W];
                r_write <= pwrite_i;
                r_wdata <= pwdata_i;
                r_strb  <= pstrb_i;
                r_cnt   <= w_wait;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_done) begin
                r_prdata <= (w_cur_write || !w_cur_ok) ? '0
                          : r_mem[w_cur_idx[MEM_AW-1:0]];
            end
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (r_strb[b]) r_mem[r_idx[MEM_AW-1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

`ifdef APB_MEM_SLVERR_EN
    logic r_slverr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slverr <= 1'b0;
        end else if (w_enter_done) begin
            r_slverr <= !w_cur_ok;
        end else if (w_next != DONE) begin
            r_slverr <= 1'b0;
        end
    end

    assign pslverr_o = r_slverr;
`else
    assign pslverr_o = 1'b0;
`endif

    assign prdata_o = r_prdata;
    assign pready_o = (r_state == DONE);

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  psel = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [12:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;

    logic [31:0] prdata0, prdata1, prdata2;
    logic        pready0, pready1, pready2;
    logic        pslverr0, pslverr1, pslverr2;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_lfsr;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    apb_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(1024), .WAIT_MODE(0)) u0 (
        .clk(clk), .reset(reset), .psel_i(psel[0]), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr[11:0]), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0));

    apb_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(1024), .WAIT_MODE(1), .FIXED_WAIT(3)) u1 (
        .clk(clk), .reset(reset), .psel_i(psel[1]), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr[11:0]), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata1), .pready_o(pready1), .pslverr_o(pslverr1));

    apb_mem_slave #(.ADDR_W(13), .DATA_W(32), .DEPTH(1024), .WAIT_MODE(2), .WAIT_MASK(7)) u2 (
        .clk(clk), .reset(reset), .psel_i(psel[2]), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata2), .pready_o(pready2), .pslverr_o(pslverr2));

    function automatic logic rdy(input int i);
        case (i)
            0: return pready0;
            1: return pready1;
            default: return pready2;
        endcase
    endfunction

    function automatic logic [31:0] rdat(input int i);
        case (i)
            0: return prdata0;
            1: return prdata1;
            default: return prdata2;
        endcase
    endfunction

    function automatic logic rerr(input int i);
        case (i)
            0: return pslverr0;
            1: return pslverr1;
            default: return pslverr2;
        endcase
    endfunction

    // Starts with a SETUP cycle in the current cycle; returns #1 after the
    // completing edge with the bus idle (a following call is back-to-back).
    task automatic apb_xfer(input int inst, input logic wr, input logic [12:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err, output int waits);
        psel[inst] = 1'b1;
        penable    = 1'b0;
        pwrite     = wr;
        paddr      = addr;
        pwdata     = wdata;
        pstrb      = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        waits   = 0;
        while (!rdy(inst) && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 40) begin
            total++; bad++;
            $display("FAIL xfer_timeout inst=%0d addr=%h: pready never rose within 40 cycles", inst, addr);
        end
        rdata = rdat(inst);
        err   = rerr(inst);
        @(posedge clk); #1;
        psel    = '0;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if ({pready0, pready1, pready2} !== 3'b000) begin bad++; $display("FAIL reset_pready got=%b exp=000", {pready0, pready1, pready2}); end
        total++; if ({pslverr0, pslverr1, pslverr2} !== 3'b000) begin bad++; $display("FAIL reset_pslverr got=%b exp=000", {pslverr0, pslverr1, pslverr2}); end
        total++; if ({prdata0, prdata1, prdata2} !== 96'h0) begin bad++; $display("FAIL reset_prdata got=%h exp=0", {prdata0, prdata1, prdata2}); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nowait();
        logic [31:0] d; logic e; int w;
        apb_xfer(0, 1'b1, 13'h010, 32'hDEADBEEF, 4'hF, d, e, w);
        total++; if (w !== 0) begin bad++; $display("FAIL nowait_wr_waits got=%0d exp=0", w); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL nowait_wr_prdata got=%h exp=00000000", d); end
        apb_xfer(0, 1'b0, 13'h010, 32'h0, 4'h0, d, e, w);
        total++; if (w !== 0) begin bad++; $display("FAIL nowait_rd_waits got=%0d exp=0", w); end
        total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL nowait_rd_data got=%h exp=deadbeef", d); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL nowait_rd_err got=%b exp=0", e); end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic e; int w;
        apb_xfer(0, 1'b1, 13'h020, 32'h11223344, 4'hF, d, e, w);
        apb_xfer(0, 1'b1, 13'h020, 32'hAABBCCDD, 4'b0101, d, e, w);
        apb_xfer(0, 1'b0, 13'h020, 32'h0, 4'h0, d, e, w);
        total++; if (d !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_merge got=%h exp=11bb33dd", d); end
        apb_xfer(0, 1'b1, 13'h020, 32'hFFFFFFFF, 4'h0, d, e, w);
        apb_xfer(0, 1'b0, 13'h021, 32'h0, 4'hF, d, e, w);
        total++; if (d !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_zero got=%h exp=11bb33dd", d); end
    endtask

    task automatic test_fixed_wait();
        logic [31:0] d; logic e; int w;
        apb_xfer(1, 1'b1, 13'h004, 32'h12345678, 4'hF, d, e, w);
        total++; if (w !== 3) begin bad++; $display("FAIL fixed_wr_waits got=%0d exp=3", w); end
        apb_xfer(1, 1'b0, 13'h004, 32'h0, 4'h0, d, e, w);
        total++; if (w !== 3) begin bad++; $display("FAIL fixed_rd_waits got=%0d exp=3", w); end
        total++; if (d !== 32'h12345678) begin bad++; $display("FAIL fixed_rd_data got=%h exp=12345678", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2; logic e; int w;
        apb_xfer(0, 1'b1, 13'h100, 32'hA5A5A5A5, 4'hF, d1, e, w);
        apb_xfer(0, 1'b1, 13'h104, 32'h5A5A0001, 4'hF, d1, e, w);
        apb_xfer(0, 1'b0, 13'h100, 32'h0, 4'h0, d1, e, w);
        apb_xfer(0, 1'b0, 13'h104, 32'h0, 4'h0, d2, e, w);
        total++; if (d1 !== 32'hA5A5A5A5) begin bad++; $display("FAIL b2b_rd0 got=%h exp=a5a5a5a5", d1); end
        total++; if (d2 !== 32'h5A5A0001) begin bad++; $display("FAIL b2b_rd1 got=%h exp=5a5a0001", d2); end
        total++; if (w !== 0) begin bad++; $display("FAIL b2b_waits got=%0d exp=0", w); end
    endtask

    task automatic test_rand_wait();
        logic [31:0] d; logic e; int w; int ew;
        for (int i = 0; i < 4; i++) begin
            ew = int'(m_lfsr[3:0] & 4'd7);
            apb_xfer(2, 1'b1, 13'(4*i), 32'h10000000 + i, 4'hF, d, e, w);
            total++; if (w !== ew) begin bad++; $display("FAIL rand_wr_waits[%0d] got=%0d exp=%0d", i, w, ew); end
        end
        for (int i = 0; i < 4; i++) begin
            ew = int'(m_lfsr[3:0] & 4'd7);
            apb_xfer(2, 1'b0, 13'(4*i), 32'h0, 4'h0, d, e, w);
            total++; if (w !== ew) begin bad++; $display("FAIL rand_rd_waits[%0d] got=%0d exp=%0d", i, w, ew); end
            total++; if (d !== 32'h10000000 + i) begin bad++; $display("FAIL rand_rd_data[%0d] got=%h exp=%h", i, d, 32'h10000000 + i); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] d; logic e; int w; int n;
        apb_xfer(2, 1'b1, 13'h030, 32'hCAFEF00D, 4'hF, d, e, w);
        n = 0;
        while ((m_lfsr[3:0] & 4'd7) == 4'd0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 13'h030; pwdata = 32'h0BADBEEF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        total++; if (pready2 !== 1'b0) begin bad++; $display("FAIL abort_in_wait got=%b exp=0", pready2); end
        psel = '0; penable = 1'b0;
        @(posedge clk); #1;
        total++; if (pready2 !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", pready2); end
        apb_xfer(2, 1'b0, 13'h030, 32'h0, 4'h0, d, e, w);
        total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL abort_old_data got=%h exp=cafef00d", d); end
    endtask

    task automatic test_slverr();
        logic [31:0] d; logic e; int w;
`ifdef APB_MEM_SLVERR_EN
        apb_xfer(2, 1'b1, 13'h1000, 32'h77777777, 4'hF, d, e, w);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL slverr_wr_err got=%b exp=1", e); end
        apb_xfer(2, 1'b0, 13'h1000, 32'h0, 4'h0, d, e, w);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL slverr_rd_err got=%b exp=1", e); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL slverr_rd_data got=%h exp=00000000", d); end
        apb_xfer(2, 1'b0, 13'h0000, 32'h0, 4'h0, d, e, w);
        total++; if (d !== 32'h10000000) begin bad++; $display("FAIL slverr_mem_kept got=%h exp=10000000", d); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL slverr_ok_err got=%b exp=0", e); end
`else
        // Index 0x400 truncates to 10 bits and aliases word 0.
        apb_xfer(2, 1'b1, 13'h1000, 32'h77777777, 4'hF, d, e, w);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL trunc_wr_err got=%b exp=0", e); end
        apb_xfer(2, 1'b0, 13'h0000, 32'h0, 4'h0, d, e, w);
        total++; if (d !== 32'h77777777) begin bad++; $display("FAIL trunc_alias got=%h exp=77777777", d); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL trunc_rd_err got=%b exp=0", e); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; int w;
        apb_xfer(0, 1'b1, 13'h040, 32'h01020304, 4'hF, d, e, w);
        apb_xfer(0, 1'b0, 13'h040, 32'h0, 4'h0, d, e, w);
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 13'h040; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        total++; if (pready0 !== 1'b1) begin bad++; $display("FAIL rstmid_in_done got=%b exp=1", pready0); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (pready0 !== 1'b0) begin bad++; $display("FAIL rstmid_pready got=%b exp=0", pready0); end
        total++; if (prdata0 !== 32'h0) begin bad++; $display("FAIL rstmid_prdata got=%h exp=00000000", prdata0); end
        total++; if (pslverr0 !== 1'b0) begin bad++; $display("FAIL rstmid_pslverr got=%b exp=0", pslverr0); end
        psel = '0; penable = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        apb_xfer(0, 1'b0, 13'h040, 32'h0, 4'h0, d, e, w);
        total++; if (d !== 32'h01020304) begin bad++; $display("FAIL rstmid_old_data got=%h exp=01020304", d); end
    endtask

    initial begin
        test_reset();
        test_nowait();
        test_strobe();
        test_fixed_wait();
        test_back_to_back();
        test_rand_wait();
        test_abort();
        test_slverr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB slave with an on-chip word memory, byte-strobe writes, programmable wait-state insertion and optional slave-error reporting. It replaces the fixed 1K×32 APB memory slave as the generic peripheral-side target.

- Width, depth and wait behaviour are set per instance.
- The block owns the full APB handshake with an explicit state machine.

## Interface
- `ADDR_W`, 12: byte-address width of `paddr_i`.
- `DATA_W`, 32: data width; 32 or 64.
- `DEPTH`, 1024: number of words in the memory.
- `WAIT_MODE`, 2: wait-state source. 0 = none, 1 = fixed, 2 = LFSR random.
- `FIXED_WAIT`, 2: wait states per transfer when `WAIT_MODE`=1; range 0..15.
- `WAIT_MASK`, 7: mask applied to the LFSR when `WAIT_MODE`=2; must be 2^k−1, at most 15.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `psel_i`  in  1  APB select.
- `penable_i`  in  1  APB enable.
- `pwrite_i`  in  1  1 = write, 0 = read.
- `paddr_i`  in  `ADDR_W`  byte address.
- `pwdata_i`  in  `DATA_W`  write data.
- `pstrb_i`  in  `DATA_W/8`  write byte strobes.
- `prdata_o`  out  `DATA_W`  read data.
- `pready_o`  out  1  transfer complete.
- `pslverr_o`  out  1  error response; valid only while `pready_o`=1.

## Operation
- **Word index:** `paddr_i[ADDR_W-1:BSH]`, where BSH = log2(`DATA_W/8`). Low BSH bits are ignored; there are no unaligned accesses.
- **States:** IDLE, WAIT, DONE.
- **IDLE:**
  - Trigger: `psel_i`=1 and `penable_i`=0 on an edge (the SETUP cycle).
  - At that edge, latch index, `pwrite_i`, `pwdata_i`, `pstrb_i` and wait count W.
  - W=0 → DONE; otherwise → WAIT with cnt=W.
- **WAIT:**
  - cnt decrements each edge.
  - Edge where cnt=1 → DONE.
- **DONE:**
  - Edge where `psel_i`&`penable_i` completes the transfer.
  - A write commits at that edge: byte i is updated iff `pstrb_i`[i]=1.
  - State returns to IDLE. The next SETUP is accepted from IDLE on the following edge.
- **Abort:** `psel_i`=0 in WAIT or DONE → IDLE with no memory update.
- **Wait count W:**
  - `WAIT_MODE`=0: W=0.
  - `WAIT_MODE`=1: W=`FIXED_WAIT`.
  - `WAIT_MODE`=2: W = lfsr[3:0] & `WAIT_MASK`.
- **LFSR:**
  - 8-bit, free-running, reset value 8'hA5.
  - Next value = {l[6:0], l[7]^l[5]^l[4]^l[3]}.
- **Read data:**
  - `prdata_o` is registered and loaded on entry to DONE with mem[index] when the transfer is a read, or 0 when it is a write.
  - The value holds until the next entry to DONE.
- **Write strobes:** a write with `pstrb_i`=0 completes normally and leaves memory unchanged. Reads ignore `pstrb_i`.
- **Memory:** contents are not reset; reads of never-written words return X in simulation.

## Timing
- **Reset values:** state IDLE, `pready_o`=0, `pslverr_o`=0, `prdata_o`=0, cnt=0, LFSR 8'hA5.
- **`pready_o`:** equals (state==DONE). It is registered with no combinational path from the APB inputs.
- **Access length:** the ACCESS phase lasts W+1 cycles. Total transfer is W+2 cycles including SETUP.
- **Reset mid-transfer:** immediate return to IDLE; a pending write is dropped.
- **Back-to-back transfers:** SETUP in the cycle after completion is accepted, with no idle cycle required.

## Configuration
- `APB_MEM_SLVERR_EN` defined:
  - An index ≥ `DEPTH` raises `pslverr_o`=1 in DONE.
  - The write is suppressed and `prdata_o`=0.
- `APB_MEM_SLVERR_EN` undefined:
  - `pslverr_o` is tied 0.
  - The index is truncated to clog2(`DEPTH`) bits.
  - Truncated indices ≥ `DEPTH` (non-power-of-two depth) read 0 and silently drop writes.

## Structure
- Package `apb_mem_pkg` holds:
  - the state enum `apb_mem_state_t` {IDLE, WAIT, DONE};
  - `WAIT_MODE` encodings `WAIT_NONE`/`WAIT_FIXED`/`WAIT_RAND`;
  - the LFSR seed constant `LFSR_SEED`=8'hA5.
- Sub-module `apb_wait_gen` holds the LFSR and W selection. Inputs: clk, reset, mode parameters. Output: W[3:0].
- The memory array and FSM live in `apb_mem_slave`.

## Test plan
- `WAIT_MODE`=0: write 32'hDEADBEEF to 0x010 with strobe 4'hF, then read 0x010 → `pready_o` high on the first ACCESS cycle; `prdata_o`=32'hDEADBEEF, `pslverr_o`=0.
- `WAIT_MODE`=1, `FIXED_WAIT`=3: a read → `pready_o` low for exactly 3 ACCESS cycles, high on the 4th.
- Write 32'h11223344 to 0x020, then write 32'hAABBCCDD with strobe 4'b0101, then read 0x020 → 32'h11BB33DD.
- `APB_MEM_SLVERR_EN` defined, `DEPTH`=1024, `ADDR_W`=13: write to 0x1000 → `pslverr_o`=1, memory unchanged. A subsequent read of 0x1000 returns 0 with `pslverr_o`=1.
- `WAIT_MODE`=2: drop `psel_i` during WAIT of a write to 0x030 → FSM returns to IDLE; a later read of 0x030 returns the old value. Also check the W sequence against an LFSR model seeded with 8'hA5.
- Assert `reset`=0 while in DONE of a write to 0x040 → outputs return to reset values next cycle; a read of 0x040 after reset shows the pre-write data.
